// File: rtl/slice_add_seq.sv
// Multi-cycle wide adder: one SLICE-bit adder slice is reused over WIDTH/SLICE
// cycles, with a registered carry chaining each slice into the next.
module slice_add_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_width
        $error("slice_add_seq: WIDTH must be a non-zero multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               cout_reg, cout_next;
    logic               carry_reg, carry_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;

    logic [NSLICE-1:0]  slice_hit;
    logic [SLICE-1:0]   a_masked [NSLICE];
    logic [SLICE-1:0]   b_masked [NSLICE];
    logic [SLICE-1:0]   a_cur;
    logic [SLICE-1:0]   b_cur;
    logic [SLICE:0]     slice_res;
    logic [WIDTH-1:0]   sum_written;

    // Per-slice decode: select the active operand slice and splice the
    // freshly computed bits into the running sum, leaving other slices alone.
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        assign slice_hit[gi] = (idx_reg == IDX_W'(gi));
        assign a_masked[gi]  = slice_hit[gi] ? a_reg[gi*SLICE +: SLICE] : '0;
        assign b_masked[gi]  = slice_hit[gi] ? b_reg[gi*SLICE +: SLICE] : '0;
        assign sum_written[gi*SLICE +: SLICE] =
            slice_hit[gi] ? slice_res[SLICE-1:0] : sum_reg[gi*SLICE +: SLICE];
    end

    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < NSLICE; i++) begin
            a_cur = a_cur | a_masked[i];
            b_cur = b_cur | b_masked[i];
        end
    end

    assign slice_res = {1'b0, a_cur} + {1'b0, b_cur} + {{SLICE{1'b0}}, carry_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            carry_reg <= carry_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        carry_next = carry_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = cin;
                    idx_next   = '0;
                    sum_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                sum_next   = sum_written;
                carry_next = slice_res[SLICE];
                // idx parks on the last slice so it never wraps mid-operation
                if (idx_reg == LAST_IDX) begin
                    cout_next  = slice_res[SLICE];
                    state_next = HOLD;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs are pure state decodes, so reset forces them at once.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == HOLD);
    assign busy      = (state_reg == CALC) || (state_reg == HOLD);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule
